// File: rtl/ram_arb_dp.sv
// ram_arb_dp: one word-wide memory array shared by a data (load/store) port
// and an instruction-fetch port. Each port has a req/gnt handshake. Reads
// have one cycle of latency and a registered rvalid. Writes use byte-lane
// enables. The arbiter lets the data port win by default, but it forces a
// fetch grant after MAX_STALL consecutive denied fetch cycles. The array
// takes at most one access per cycle.
//
// Optional feature, selected by the macro RAM_OOR_ERR_EN:
//   defined   - a granted access with any address bit above the index range
//               set is blocked. Writes are dropped, reads return zero, and
//               err pulses for one cycle after the grant.
//   undefined - the upper address bits are ignored, so addresses alias, and
//               err is tied low.
//
// ADDR_W must be below 32. DATA_W must be a multiple of 8.

module ram_arb_dp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int MAX_STALL = 4
) (
    input  logic                clk,
    input  logic                rst,
    // data (load/store) port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [31:0]         d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    // instruction-fetch port (read only)
    input  logic                f_req,
    input  logic [31:0]         f_addr,
    output logic                f_gnt,
    output logic                f_rvalid,
    output logic [DATA_W-1:0]   f_rdata,
    // out-of-range access flag
    output logic                err
);

    localparam int NBYTES  = DATA_W / 8;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int STALL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_STALL);

    // Storage and registered state
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               d_rvalid_q, d_rvalid_d;
    logic               f_rvalid_q, f_rvalid_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0]  f_rdata_q, f_rdata_d;

    // Decoded per-port indices and the single shared array access
    logic [ADDR_W-1:0]  d_idx, f_idx;
    logic               d_oor, f_oor;
    logic               force_fetch;
    logic [ADDR_W-1:0]  acc_idx;
    logic               acc_we;
    logic               acc_oor;
    logic [DATA_W-1:0]  rd_word;

    assign d_idx = d_addr[ADDR_W-1:0];
    assign f_idx = f_addr[ADDR_W-1:0];

`ifdef RAM_OOR_ERR_EN
    logic err_q, err_d;

    assign d_oor = |d_addr[31:ADDR_W];
    assign f_oor = |f_addr[31:ADDR_W];

    // Raise the error flag in the cycle after a granted out-of-range access
    always_comb begin
        err_d = (d_gnt && d_oor) || (f_gnt && f_oor);
    end

    // Register the error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_addr_bits;

    // The upper address bits alias onto the array. They are only folded
    // together here so that it is clear they are deliberately ignored.
    assign unused_addr_bits = ^{d_addr[31:ADDR_W], f_addr[31:ADDR_W]};
    assign d_oor            = 1'b0;
    assign f_oor            = 1'b0;
    assign err              = 1'b0;
`endif

    // Fixed data priority, with a fetch grant forced once the stall limit is reached
    // NOTE: every output of a combinational block gets a default first; a
    // path that leaves one unassigned would infer a latch.
    always_comb begin
        force_fetch = (MAX_STALL != 0) && (stall_cnt_q == STALL_LIMIT);
        d_gnt       = 1'b0;
        f_gnt       = 1'b0;
        if (!rst) begin
            if (d_req && f_req) begin
                f_gnt = force_fetch;
                d_gnt = !force_fetch;
            end else begin
                d_gnt = d_req;
                f_gnt = f_req;
            end
        end
    end

    // Count consecutive denied fetch cycles, saturating at the limit
    always_comb begin
        stall_cnt_d = '0;
        if (f_req && !f_gnt) begin
            if (stall_cnt_q == STALL_LIMIT) begin
                stall_cnt_d = stall_cnt_q;
            end else begin
                stall_cnt_d = stall_cnt_q + STALL_W'(1);
            end
        end
    end

    // Select the one array access allowed this cycle (at most one grant is high)
    always_comb begin
        acc_idx = d_idx;
        acc_we  = 1'b0;
        acc_oor = 1'b0;
        if (f_gnt) begin
            acc_idx = f_idx;
            acc_oor = f_oor;
        end else if (d_gnt) begin
            acc_we  = d_we;
            acc_oor = d_oor;
        end
    end

    // Next read data and valids. Each rdata holds its value until its port's next read
    always_comb begin
        rd_word    = acc_oor ? '0 : mem_q[acc_idx];
        d_rvalid_d = d_gnt && !d_we;
        f_rvalid_d = f_gnt;
        d_rdata_d  = d_rdata_q;
        f_rdata_d  = f_rdata_q;
        if (d_rvalid_d) begin
            d_rdata_d = rd_word;
        end
        if (f_rvalid_d) begin
            f_rdata_d = rd_word;
        end
    end

    // Byte-lane write into the array on a granted in-range store
    // NOTE: the array is deliberately left out of reset. Its contents survive
    // rst, and a reset on it would stop it mapping onto RAM macros.
    always_ff @(posedge clk) begin
        if (acc_we && !acc_oor) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (d_be[i]) begin
                    mem_q[acc_idx][i*8 +: 8] <= d_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Port-side registers: stall counter, read valids and held read data
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            d_rvalid_q  <= 1'b0;
            f_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            f_rdata_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            d_rvalid_q  <= d_rvalid_d;
            f_rvalid_q  <= f_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            f_rdata_q   <= f_rdata_d;
        end
    end

    assign d_rvalid = d_rvalid_q;
    assign f_rvalid = f_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign f_rdata  = f_rdata_q;

endmodule

// File: tb/tb_ram_arb_dp.sv
// Testbench for ram_arb_dp. It applies directed per-cycle vectors. A
// transaction-level model (a sparse word map and a stall counter) predicts the
// grants, read valids, read data and err on every cycle. Literal checks pin
// the key scenarios: reset, byte lanes, the arbitration pattern and burst
// fetch.

module tb_ram_arb_dp;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 16;
    localparam int MAX_STALL = 4;
    localparam int DEPTH     = 1 << ADDR_W;
`ifdef RAM_OOR_ERR_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    ram_arb_dp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_STALL(MAX_STALL)
    ) dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model, evaluated at every falling edge
    // ------------------------------------------------------------------
    logic [31:0] mdl_mem [int];
    int          m_stall = 0;
    logic        exp_d_rvalid = 0, exp_f_rvalid = 0, exp_err = 0;
    logic [31:0] exp_d_rdata = 0, exp_f_rdata = 0;
    bit          d_known = 1, f_known = 1;
    logic        eg_d, eg_f;

    function automatic bit is_oor(input logic [31:0] a);
        return OOR_EN && ((a >> ADDR_W) != 0);
    endfunction

    always @(negedge clk) begin
        int  idx;
        bit  oor;
        if (rst) begin
            exp_d_rvalid = 0; exp_f_rvalid = 0; exp_err = 0;
            exp_d_rdata  = 0; exp_f_rdata  = 0;
            d_known = 1; f_known = 1; m_stall = 0;
        end
        check("d_rvalid", d_rvalid, exp_d_rvalid);
        check("f_rvalid", f_rvalid, exp_f_rvalid);
        check("err", err, exp_err);
        if (d_known) check("d_rdata", d_rdata, exp_d_rdata);
        if (f_known) check("f_rdata", f_rdata, exp_f_rdata);

        if (rst) begin
            eg_d = 0; eg_f = 0;
        end else if (d_req && f_req) begin
            eg_f = (MAX_STALL != 0) && (m_stall >= MAX_STALL);
            eg_d = !eg_f;
        end else begin
            eg_d = d_req; eg_f = f_req;
        end
        check("d_gnt", d_gnt, eg_d);
        check("f_gnt", f_gnt, eg_f);

        if (!rst) begin
            exp_d_rvalid = 0; exp_f_rvalid = 0; exp_err = 0;
            if (eg_d) begin
                oor = is_oor(d_addr);
                idx = int'(d_addr % DEPTH);
                exp_err = oor;
                if (d_we) begin
                    if (!oor && d_be != 0) begin
                        logic [31:0] w;
                        w = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (d_be[b]) w[b*8 +: 8] = d_wdata[b*8 +: 8];
                        mdl_mem[idx] = w;
                    end
                end else begin
                    exp_d_rvalid = 1;
                    d_known      = oor || mdl_mem.exists(idx);
                    exp_d_rdata  = oor ? 32'h0 : (d_known ? mdl_mem[idx] : 32'h0);
                end
            end
            if (eg_f) begin
                oor = is_oor(f_addr);
                idx = int'(f_addr % DEPTH);
                exp_err      = oor;
                exp_f_rvalid = 1;
                f_known      = oor || mdl_mem.exists(idx);
                exp_f_rdata  = oor ? 32'h0 : (f_known ? mdl_mem[idx] : 32'h0);
            end
            if (f_req && !eg_f) m_stall = (m_stall < MAX_STALL) ? m_stall + 1 : MAX_STALL;
            else                m_stall = 0;
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    // One clock cycle: drive inputs, sample grants mid-cycle, advance to edge+1.
    task automatic step(input logic r, input logic dq, input logic dwe,
                        input logic [3:0] dbe, input logic [31:0] da,
                        input logic [31:0] dwd, input logic fq,
                        input logic [31:0] fa,
                        output logic gd, output logic gf);
        rst = r; d_req = dq; d_we = dwe; d_be = dbe; d_addr = da;
        d_wdata = dwd; f_req = fq; f_addr = fa;
        #2;
        gd = d_gnt; gf = f_gnt;
        @(posedge clk);
        #1;
    endtask

    logic gd, gf;
    logic [5:0] pat_d, pat_f;
    logic [31:0] burst [4];

    task automatic idle();
        step(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, gd, gf);
    endtask
    task automatic dwr(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        step(0, 1, 1, be, a, w, 0, 32'h0, gd, gf);
    endtask
    task automatic drd(input logic [31:0] a);
        step(0, 1, 0, 4'h0, a, 32'h0, 0, 32'h0, gd, gf);
    endtask
    task automatic frd(input logic [31:0] a);
        step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, a, gd, gf);
    endtask

    initial begin
        burst[0] = 32'hAAAA_0000; burst[1] = 32'hBBBB_1111;
        burst[2] = 32'hCCCC_2222; burst[3] = 32'hDDDD_3333;

        // Reset state
        step(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, gd, gf);
        step(1, 1, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0, gd, gf);
        check("rst_gnt", {gd, gf}, 2'b00);
        check("rst_outs", {d_rvalid, f_rvalid, err}, 3'b000);
        check("rst_rdata", d_rdata | f_rdata, 32'h0);
        idle();

        // Full-word write, then read back
        dwr(32'h10, 32'hDEADBEEF, 4'hF);
        drd(32'h10);
        check("wr_rd_valid", d_rvalid, 1'b1);
        check("wr_rd_data", d_rdata, 32'hDEADBEEF);
        idle();
        check("rvalid_one_cycle", d_rvalid, 1'b0);
        check("rdata_hold", d_rdata, 32'hDEADBEEF);

        // Reset asserted during a requested read: no grant, no rvalid
        step(1, 1, 0, 4'h0, 32'h10, 32'h0, 0, 32'h0, gd, gf);
        check("rst_read_gnt", gd, 1'b0);
        check("rst_read_rvalid", d_rvalid, 1'b0);
        check("rst_read_rdata", d_rdata, 32'h0);
        idle();
        check("rst_release_rvalid", d_rvalid, 1'b0);

        // Byte-lane write, then a be=0 write that must not change anything
        dwr(32'h10, 32'h11223344, 4'b0101);
        drd(32'h10);
        check("byte_lane", d_rdata, 32'hDE22BE44);
        dwr(32'h10, 32'hFFFFFFFF, 4'h0);
        drd(32'h10);
        check("be_zero_noop", d_rdata, 32'hDE22BE44);

        // Preload words 0..3, then four back-to-back fetches
        for (int i = 0; i < 4; i++) dwr(i, burst[i], 4'hF);
        for (int i = 0; i < 4; i++) begin
            frd(i);
            check("burst_rvalid", f_rvalid, 1'b1);
            check("burst_rdata", f_rdata, burst[i]);
        end
        idle();

        // A write followed directly by a fetch of the same word
        dwr(32'h20, 32'h12345678, 4'hF);
        frd(32'h20);
        check("wr_then_fetch", f_rdata, 32'h12345678);

        // Both ports contend for six cycles with MAX_STALL=4
        for (int c = 0; c < 6; c++) begin
            step(0, 1, 0, 4'h0, 32'h10, 32'h0, 1, 32'h1, gd, gf);
            pat_d[c] = gd; pat_f[c] = gf;
        end
        check("arb_d_pattern", pat_d, 6'b101111);
        check("arb_f_pattern", pat_f, 6'b010000);

        // Longer contention with mixed writes and reads; fetch keeps asking
        for (int c = 0; c < 12; c++)
            step(0, 1, c[0], 4'hF, 32'h40 + c, 32'h5000 + c, 1, 32'h2, gd, gf);
        // Dropping f_req clears the stall count
        step(0, 1, 0, 4'h0, 32'h10, 32'h0, 1, 32'h3, gd, gf);
        step(0, 1, 0, 4'h0, 32'h10, 32'h0, 1, 32'h3, gd, gf);
        drd(32'h10);
        for (int c = 0; c < 5; c++)
            step(0, 1, 0, 4'h0, 32'h41, 32'h0, 1, 32'h3, gd, gf);
        idle();

        // Upper address bits: aliasing or out-of-range error
        frd(32'h0001_0000);
`ifdef RAM_OOR_ERR_EN
        check("oor_fetch_data", f_rdata, 32'h0);
        check("oor_fetch_err", err, 1'b1);
`else
        check("alias_fetch_data", f_rdata, burst[0]);
        check("alias_fetch_err", err, 1'b0);
`endif
        idle();
        check("err_one_cycle", err, 1'b0);
        dwr(32'h0001_0020, 32'hCAFEF00D, 4'hF);
        drd(32'h20);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
